// File: rtl/tuner_phy_pkg.sv
// Shared types for the tuner controller: coarse-search FSM states and the
// flag bundle that each state decodes to.
package tuner_phy_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    COMMIT,
    TUNE,
    PARK,
    DONE
  } tuner_ctrl_search_state_e;

  typedef struct packed {
    logic busy;
    logic active;
    logic refresh;
    logic tune_val;
    logic commit_rdy;
    logic done;
  } search_flags_t;

  // Handshake and status flags are a pure function of the state they are registered with.
  function automatic search_flags_t state_flags(input tuner_ctrl_search_state_e st);
    search_flags_t f;
    f            = '0;
    f.busy       = (st != IDLE);
    f.active     = (st == INIT) || (st == COMMIT) || (st == TUNE) || (st == PARK);
    f.refresh    = (st == INIT);
    f.tune_val   = (st == TUNE) || (st == PARK);
    f.commit_rdy = (st == COMMIT);
    f.done       = (st == DONE);
    return f;
  endfunction

endpackage

// File: rtl/tuner_ctrl_search_if.sv
// Search control/status plus the tune and commit handshakes between the
// coarse-search controller (master) and its arbiter/host (slave).
interface tuner_ctrl_search_if #(
  parameter int DAC_WIDTH = 8,
  parameter int ADC_WIDTH = 8
);

  logic                 i_search_start;
  logic                 i_search_abort;
  logic [DAC_WIDTH-1:0] i_search_code_min;
  logic [DAC_WIDTH-1:0] i_search_code_max;
  logic [DAC_WIDTH-1:0] i_search_code_stride;
  logic                 o_search_busy;
  logic                 o_search_done;
  logic                 o_search_err;
  logic [DAC_WIDTH-1:0] o_search_peak_code;
  logic [ADC_WIDTH-1:0] o_search_peak_pwr;
  logic                 o_ctrl_active;
  logic                 o_ctrl_refresh;
  logic                 o_ctrl_ring_tune_val;
  logic                 i_ctrl_ring_tune_rdy;
  logic [DAC_WIDTH-1:0] o_ctrl_ring_tune;
  logic                 i_ctrl_commit_val;
  logic                 o_ctrl_commit_rdy;
  logic [ADC_WIDTH-1:0] i_ctrl_pwr_commit;
  logic [DAC_WIDTH-1:0] i_ctrl_ring_tune_commit;

  modport master (
    input  i_search_start, i_search_abort,
    input  i_search_code_min, i_search_code_max, i_search_code_stride,
    output o_search_busy, o_search_done, o_search_err,
    output o_search_peak_code, o_search_peak_pwr,
    output o_ctrl_active, o_ctrl_refresh,
    output o_ctrl_ring_tune_val, o_ctrl_ring_tune,
    input  i_ctrl_ring_tune_rdy,
    input  i_ctrl_commit_val, i_ctrl_pwr_commit, i_ctrl_ring_tune_commit,
    output o_ctrl_commit_rdy
  );

  modport slave (
    output i_search_start, i_search_abort,
    output i_search_code_min, i_search_code_max, i_search_code_stride,
    input  o_search_busy, o_search_done, o_search_err,
    input  o_search_peak_code, o_search_peak_pwr,
    input  o_ctrl_active, o_ctrl_refresh,
    input  o_ctrl_ring_tune_val, o_ctrl_ring_tune,
    output i_ctrl_ring_tune_rdy,
    output i_ctrl_commit_val, i_ctrl_pwr_commit, i_ctrl_ring_tune_commit,
    input  o_ctrl_commit_rdy
  );

endinterface

// File: rtl/tuner_search_peak_track.sv
// Tracks the (code, power) pair with the strictly highest power seen since
// the last clear; ties keep the earlier sample.
module tuner_search_peak_track #(
  parameter int DAC_WIDTH = 8,
  parameter int ADC_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 update,
  input  logic [DAC_WIDTH-1:0] code,
  input  logic [ADC_WIDTH-1:0] power,
  output logic [DAC_WIDTH-1:0] peak_code,
  output logic [ADC_WIDTH-1:0] peak_pwr,
  output logic                 valid
);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      peak_code <= '0;
      peak_pwr  <= '0;
      valid     <= 1'b0;
    end else if (clear) begin
      peak_code <= '0;
      peak_pwr  <= '0;
      valid     <= 1'b0;
    end else if (update && (!valid || (power > peak_pwr))) begin
      peak_code <= code;
      peak_pwr  <= power;
      valid     <= 1'b1;
    end
  end

endmodule

// File: rtl/tuner_ctrl_search.sv
// Coarse-search controller: sweeps the ring-tune code min..max in strides,
// tracks the peak-power code from committed samples, then parks on it.
module tuner_ctrl_search
  import tuner_phy_pkg::*;
#(
  parameter int DAC_WIDTH = 8,
  parameter int ADC_WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  tuner_ctrl_search_if.master bus
);

  tuner_ctrl_search_state_e state;
  search_flags_t            flags;

  logic [DAC_WIDTH-1:0] cur;
  logic [DAC_WIDTH-1:0] max_code;
  logic [DAC_WIDTH-1:0] stride;
  logic [DAC_WIDTH-1:0] tune_code;
  logic [DAC_WIDTH-1:0] park_code;
  logic [DAC_WIDTH:0]   next_code;
  logic                 last_tuned;
  logic                 stale;
  logic                 err;
  logic                 cfg_bad;
  logic                 start_ok;
  logic                 tune_fire;
  logic                 commit_fire;
  logic                 peak_update;
  logic                 peak_valid;
  logic [DAC_WIDTH-1:0] peak_code;
  logic [ADC_WIDTH-1:0] peak_pwr;

  assign cfg_bad     = (bus.i_search_code_min > bus.i_search_code_max) ||
                       (bus.i_search_code_stride == '0);
  assign start_ok    = (state == IDLE) && bus.i_search_start && !bus.i_search_abort && !cfg_bad;
  assign tune_fire   = flags.tune_val && bus.i_ctrl_ring_tune_rdy;
  assign commit_fire = flags.commit_rdy && bus.i_ctrl_commit_val;
  // One extra bit so a step past the top of the DAC range is seen as "beyond max", not a wrap.
  assign next_code   = {1'b0, cur} + {1'b0, stride};
  assign peak_update = commit_fire && !stale && !bus.i_search_abort;
  assign park_code   = peak_valid ? peak_code : cur;

  tuner_search_peak_track #(
    .DAC_WIDTH (DAC_WIDTH),
    .ADC_WIDTH (ADC_WIDTH)
  ) u_peak (
    .clk       (i_clk),
    .rst_n     (i_rst_n),
    .clear     (start_ok),
    .update    (peak_update),
    .code      (bus.i_ctrl_ring_tune_commit),
    .power     (bus.i_ctrl_pwr_commit),
    .peak_code (peak_code),
    .peak_pwr  (peak_pwr),
    .valid     (peak_valid)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      flags      <= '0;
      cur        <= '0;
      max_code   <= '0;
      stride     <= '0;
      tune_code  <= '0;
      last_tuned <= 1'b0;
      stale      <= 1'b0;
      err        <= 1'b0;
    end else begin
      err <= 1'b0;
      // Remember the parked code so it stays on the bus after PARK is left.
      if (state == PARK) tune_code <= park_code;
      if (bus.i_search_abort) begin
        state <= IDLE;
        flags <= state_flags(IDLE);
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_search_start) begin
              if (cfg_bad) begin
                err <= 1'b1;
              end else begin
                cur        <= bus.i_search_code_min;
                max_code   <= bus.i_search_code_max;
                stride     <= bus.i_search_code_stride;
                last_tuned <= 1'b0;
                stale      <= 1'b1;
                state      <= INIT;
                flags      <= state_flags(INIT);
              end
            end
          end
          INIT: begin
            state <= COMMIT;
            flags <= state_flags(COMMIT);
          end
          COMMIT: begin
            if (commit_fire) begin
              stale <= 1'b0;
              if (last_tuned) begin
                state <= PARK;
                flags <= state_flags(PARK);
              end else begin
                tune_code <= cur;
                state     <= TUNE;
                flags     <= state_flags(TUNE);
              end
            end
          end
          TUNE: begin
            if (tune_fire) begin
              if (next_code > {1'b0, max_code}) last_tuned <= 1'b1;
              else cur <= next_code[DAC_WIDTH-1:0];
              state <= COMMIT;
              flags <= state_flags(COMMIT);
            end
          end
          PARK: begin
            if (tune_fire) begin
              state <= DONE;
              flags <= state_flags(DONE);
            end
          end
          DONE: begin
            state <= IDLE;
            flags <= state_flags(IDLE);
          end
          default: begin
            state <= IDLE;
            flags <= state_flags(IDLE);
          end
        endcase
      end
    end
  end

  assign bus.o_search_busy        = flags.busy;
  assign bus.o_search_done        = flags.done;
  assign bus.o_search_err         = err;
  assign bus.o_search_peak_code   = peak_code;
  assign bus.o_search_peak_pwr    = peak_pwr;
  assign bus.o_ctrl_active        = flags.active;
  assign bus.o_ctrl_refresh       = flags.refresh;
  assign bus.o_ctrl_ring_tune_val = flags.tune_val;
  assign bus.o_ctrl_commit_rdy    = flags.commit_rdy;
  assign bus.o_ctrl_ring_tune     = (state == PARK) ? park_code : tune_code;

endmodule

// File: tb/tb_tuner_ctrl_search.sv
// Bench for tuner_ctrl_search: an arbiter model (tune -> commit of the looked-up
// power) with random stalls, checked against a sweep/peak reference model.
module tb_tuner_ctrl_search;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int RUN_LIMIT = 6000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  tuner_ctrl_search_if #(.DAC_WIDTH(DW), .ADC_WIDTH(AW)) bus ();

  tuner_ctrl_search #(.DAC_WIDTH(DW), .ADC_WIDTH(AW)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] pwr_lut [256];
  int            tuned_q [$];
  int            commits;
  bit            done_seen;
  bit            done_active;
  bit            saw_refresh;
  bit            pend;
  logic [DW-1:0] pend_code;
  logic [AW-1:0] pend_pwr;
  logic [AW-1:0] stale_pwr;
  int            bp_max;
  int            tstall;
  int            cstall;
  bit            quiet;
  bit            prev_tval;
  bit            prev_tfire;
  logic [DW-1:0] prev_tcode;
  bit            last_tfire;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] allOutputs();
    return 32'({bus.o_search_busy, bus.o_search_done, bus.o_search_err,
                bus.o_search_peak_code, bus.o_search_peak_pwr, bus.o_ctrl_active,
                bus.o_ctrl_refresh, bus.o_ctrl_ring_tune_val, bus.o_ctrl_ring_tune,
                bus.o_ctrl_commit_rdy});
  endfunction

  // One arbiter cycle: observe at the falling edge, then drive for the next rising edge.
  task automatic arbStep();
    bit tval, crdy, trdy, cval;
    @(negedge clk);
    tval = bus.o_ctrl_ring_tune_val;
    crdy = bus.o_ctrl_commit_rdy;
    saw_refresh = bus.o_ctrl_refresh;
    if (bus.o_search_done) begin
      done_seen   = 1'b1;
      done_active = bus.o_ctrl_active;
    end
    checkOutput("val_rdy_exclusive", 32'(tval & crdy), 32'd0);
    if (prev_tval && !prev_tfire) begin
      checkOutput("tune_val_held", 32'(tval), 32'd1);
      checkOutput("tune_code_held", 32'(bus.o_ctrl_ring_tune), 32'(prev_tcode));
    end
    if (bus.o_ctrl_refresh) begin
      pend      = 1'b1;
      pend_code = DW'($urandom);
      pend_pwr  = stale_pwr;
      cstall    = $urandom_range(0, bp_max);
    end
    trdy = 1'b0;
    if (tval && !quiet) begin
      if (tstall > 0) tstall--;
      else trdy = 1'b1;
    end
    cval = 1'b0;
    if (pend && !quiet) begin
      if (cstall > 0) cstall--;
      else cval = 1'b1;
    end
    bus.i_ctrl_ring_tune_rdy    = trdy;
    bus.i_ctrl_commit_val       = cval;
    bus.i_ctrl_pwr_commit       = pend_pwr;
    bus.i_ctrl_ring_tune_commit = pend_code;
    last_tfire = tval && trdy;
    if (cval && crdy) begin
      pend = 1'b0;
      commits++;
      cstall = $urandom_range(0, bp_max);
    end
    if (last_tfire) begin
      tuned_q.push_back(int'(bus.o_ctrl_ring_tune));
      pend      = 1'b1;
      pend_code = bus.o_ctrl_ring_tune;
      pend_pwr  = pwr_lut[bus.o_ctrl_ring_tune];
      tstall    = $urandom_range(0, bp_max);
    end
    prev_tval  = tval && !quiet;
    prev_tcode = bus.o_ctrl_ring_tune;
    prev_tfire = last_tfire;
  endtask

  task automatic beginRun(input int mn, input int mx, input int st, input int bp,
                          input logic [AW-1:0] stale);
    tuned_q.delete();
    commits     = 0;
    done_seen   = 1'b0;
    done_active = 1'b0;
    pend        = 1'b0;
    prev_tval   = 1'b0;
    quiet       = 1'b0;
    bp_max      = bp;
    tstall      = 0;
    cstall      = 0;
    stale_pwr   = stale;
    bus.i_search_code_min    = DW'(mn);
    bus.i_search_code_max    = DW'(mx);
    bus.i_search_code_stride = DW'(st);
    bus.i_search_start       = 1'b1;
    arbStep();
    bus.i_search_start = 1'b0;
  endtask

  // Full sweep; the expected tune order and peak come from the plain sweep rule.
  task automatic applyStimulus(input string tag, input int mn, input int mx, input int st,
                               input int bp, input logic [AW-1:0] stale);
    int exp_codes [$];
    int best_code, best_pwr, n;
    beginRun(mn, mx, st, bp, stale);
    checkOutput($sformatf("%s refresh_after_start", tag), 32'(saw_refresh), 32'd1);
    for (int cyc = 0; cyc < RUN_LIMIT && !done_seen; cyc++) arbStep();
    checkOutput($sformatf("%s done_within_limit", tag), 32'(done_seen), 32'd1);
    best_code = mn;
    best_pwr  = int'(pwr_lut[mn]);
    for (int c = mn; c <= mx; c += st) begin
      exp_codes.push_back(c);
      if (int'(pwr_lut[c]) > best_pwr) begin
        best_pwr  = int'(pwr_lut[c]);
        best_code = c;
      end
    end
    exp_codes.push_back(best_code);
    n = exp_codes.size() - 1;
    checkOutput($sformatf("%s tune_count", tag), 32'(tuned_q.size()), 32'(n + 1));
    for (int i = 0; i < exp_codes.size() && i < tuned_q.size(); i++)
      checkOutput($sformatf("%s tune_code[%0d]", tag, i), 32'(tuned_q[i]), 32'(exp_codes[i]));
    checkOutput($sformatf("%s commit_count", tag), 32'(commits), 32'(n + 1));
    checkOutput($sformatf("%s active_at_done", tag), 32'(done_active), 32'd0);
    checkOutput($sformatf("%s peak_code", tag), 32'(bus.o_search_peak_code), 32'(best_code));
    checkOutput($sformatf("%s peak_pwr", tag), 32'(bus.o_search_peak_pwr), 32'(best_pwr));
    arbStep();
    checkOutput($sformatf("%s busy_after_done", tag), 32'(bus.o_search_busy), 32'd0);
    checkOutput($sformatf("%s done_one_cycle", tag), 32'(bus.o_search_done), 32'd0);
    checkOutput($sformatf("%s park_code_held", tag), 32'(bus.o_ctrl_ring_tune), 32'(best_code));
  endtask

  task automatic applyConfigError(input string tag, input int mn, input int mx, input int st);
    beginRun(mn, mx, st, 0, '0);
    checkOutput($sformatf("%s err_pulse", tag), 32'(bus.o_search_err), 32'd1);
    checkOutput($sformatf("%s busy_low", tag), 32'(bus.o_search_busy), 32'd0);
    arbStep();
    checkOutput($sformatf("%s err_cleared", tag), 32'(bus.o_search_err), 32'd0);
    checkOutput($sformatf("%s still_idle", tag), 32'(bus.o_search_busy), 32'd0);
  endtask

  task automatic fillBasicLut();
    for (int c = 0; c < 256; c++) pwr_lut[c] = AW'(c % 128);
    pwr_lut[24] = 8'd200;
  endtask

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    bus.i_search_start          = 1'b0;
    bus.i_search_abort          = 1'b0;
    bus.i_search_code_min       = '0;
    bus.i_search_code_max       = '0;
    bus.i_search_code_stride    = '0;
    bus.i_ctrl_ring_tune_rdy    = 1'b0;
    bus.i_ctrl_commit_val       = 1'b0;
    bus.i_ctrl_pwr_commit       = '0;
    bus.i_ctrl_ring_tune_commit = '0;
    bp_max = 0;
    quiet  = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_outputs", allOutputs(), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    fillBasicLut();
    applyStimulus("basic", 0, 40, 8, 0, 8'd0);
    applyStimulus("basic_bp", 0, 40, 8, 10, 8'd0);
    applyStimulus("wrap", 250, 255, 4, 3, 8'd0);
    applyStimulus("full_range", 0, 255, 51, 2, 8'd0);

    for (int c = 0; c < 256; c++) pwr_lut[c] = 8'd50;
    applyStimulus("tie_stale", 17, 97, 16, 4, 8'd255);

    applyConfigError("stride0", 5, 20, 0);
    applyConfigError("min_gt_max", 9, 3, 2);

    // Abort while tuning the third code; peak reflects only the two evaluated codes.
    fillBasicLut();
    beginRun(0, 40, 8, 2, 8'd0);
    for (int cyc = 0; cyc < RUN_LIMIT; cyc++) begin
      arbStep();
      if (bus.o_ctrl_ring_tune_val && (tuned_q.size() - (last_tfire ? 1 : 0)) == 2) break;
    end
    if (last_tfire) void'(tuned_q.pop_back());
    checkOutput("abort tuned_before", 32'(tuned_q.size()), 32'd2);
    bus.i_search_abort       = 1'b1;
    bus.i_ctrl_ring_tune_rdy = 1'b0;
    bus.i_ctrl_commit_val    = 1'b0;
    pend      = 1'b0;
    prev_tval = 1'b0;
    quiet     = 1'b1;
    arbStep();
    bus.i_search_abort = 1'b0;
    checkOutput("abort busy", 32'(bus.o_search_busy), 32'd0);
    checkOutput("abort active", 32'(bus.o_ctrl_active), 32'd0);
    checkOutput("abort tune_val", 32'(bus.o_ctrl_ring_tune_val), 32'd0);
    checkOutput("abort commit_rdy", 32'(bus.o_ctrl_commit_rdy), 32'd0);
    checkOutput("abort peak_code", 32'(bus.o_search_peak_code), 32'd8);
    checkOutput("abort peak_pwr", 32'(bus.o_search_peak_pwr), 32'd8);
    repeat (4) arbStep();
    checkOutput("abort no_done", 32'(done_seen), 32'd0);

    // Reset in the middle of a sweep.
    beginRun(0, 40, 8, 1, 8'd0);
    repeat (12) arbStep();
    rst_n = 1'b0;
    bus.i_ctrl_ring_tune_rdy = 1'b0;
    bus.i_ctrl_commit_val    = 1'b0;
    quiet     = 1'b1;
    prev_tval = 1'b0;
    arbStep();
    checkOutput("midsweep_reset outputs", allOutputs(), 32'd0);
    rst_n = 1'b1;
    arbStep();
    applyStimulus("after_reset", 0, 40, 8, 3, 8'd0);

    for (int r = 0; r < 5; r++) begin
      int mn, mx, st;
      mn = $urandom_range(0, 200);
      mx = $urandom_range(mn, 255);
      st = $urandom_range(1, 32);
      for (int c = 0; c < 256; c++) pwr_lut[c] = AW'($urandom);
      applyStimulus($sformatf("rand%0d", r), mn, mx, st, 10, AW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
